ifetch_unit: RTL and testbench

- Instruction fetch stage upstream of the instruction decoder.
- Owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched instructions with their PCs in a 2-entry FIFO, presented to the decoder over valid/ready.
- Accepts branch/jump redirects from the controller; a redirect flushes the FIFO and any in-flight fetch.

---
 rtl/ifetch_unit.sv | 139 +++++++++++++
 tb/tb_ifetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads imem over req/ack and
// queues {pc, insn} pairs in a 2-entry FIFO toward the decoder.
//
// Ports:
//   clk, clr_n                 clock, async active-low reset
//   imem_req/addr/ack/rdata    instruction memory handshake
//   ins_valid/ready/out,pc_out decoder-side FIFO head
//   redirect, redirect_pc      branch/jump redirect from controller
module ifetch_unit #(
  parameter int PCW = 6,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           clr_n,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [DW-1:0]  imem_rdata,
  output logic           ins_valid,
  input  logic           ins_ready,
  output logic [DW-1:0]  ins_out,
  output logic [PCW-1:0] pc_out,
  input  logic           redirect,
  input  logic [PCW-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FULL,
    S_DROP
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PCW-1:0] drop_pc_q, drop_pc_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [DW-1:0]  hd_ins_q, hd_ins_d;
  logic [PCW-1:0] hd_pc_q, hd_pc_d;
  logic [DW-1:0]  tl_ins_q, tl_ins_d;
  logic [PCW-1:0] tl_pc_q, tl_pc_d;

  logic       pop;
  logic       push;
  logic [1:0] cnt_pop;

  // Head entry doubles as the output register, so it keeps its
  // last value once the FIFO drains.
  assign ins_valid = (cnt_q != 2'd0);
  assign ins_out   = hd_ins_q;
  assign pc_out    = hd_pc_q;

  // A dropped request must keep its original address until acked.
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr = (state_q == S_DROP) ? drop_pc_q : fetch_pc_q;

  assign pop     = ins_valid & ins_ready & ~redirect;
  assign push    = (state_q == S_FETCH) & imem_ack & ~redirect;
  assign cnt_pop = cnt_q - {1'b0, pop};

  always_comb begin
    hd_ins_d = hd_ins_q;
    hd_pc_d  = hd_pc_q;
    tl_ins_d = tl_ins_q;
    tl_pc_d  = tl_pc_q;
    if (pop && cnt_q == 2'd2) begin
      hd_ins_d = tl_ins_q;
      hd_pc_d  = tl_pc_q;
    end
    unique case (1'b1)
      push && cnt_pop == 2'd0: begin
        hd_ins_d = imem_rdata;
        hd_pc_d  = fetch_pc_q;
      end
      push && cnt_pop == 2'd1: begin
        tl_ins_d = imem_rdata;
        tl_pc_d  = fetch_pc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    drop_pc_d  = drop_pc_q;
    cnt_d      = redirect ? 2'd0 : cnt_pop + {1'b0, push};
    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = redirect_pc;
    else if (push)
      fetch_pc_d = fetch_pc_q + PCW'(1);
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          // Unacked request must still be completed by memory.
          if (!imem_ack) begin
            state_d   = S_DROP;
            drop_pc_d = fetch_pc_q;
          end
        end else if (imem_ack && cnt_d == 2'd2) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect || pop)
          state_d = S_FETCH;
      end
      S_DROP: begin
        if (imem_ack)
          state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      drop_pc_q  <= '0;
      cnt_q      <= 2'd0;
      hd_ins_q   <= '0;
      hd_pc_q    <= '0;
      tl_ins_q   <= '0;
      tl_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_pc_q  <= drop_pc_d;
      cnt_q      <= cnt_d;
      hd_ins_q   <= hd_ins_d;
      hd_pc_q    <= hd_pc_d;
      tl_ins_q   <= tl_ins_d;
      tl_pc_q    <= tl_pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: variable-latency memory model plus a
// scoreboard of expected {pc, insn} deliveries.
module tb_ifetch_unit;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk;
  logic        clr_n;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_out;
  logic [5:0]  pc_out;
  logic        redirect;
  logic [5:0]  redirect_pc;

  int n_chk;
  int n_fail;
  int exp_q[$];
  int lat;
  int wcnt;
  int cyc;
  int ack_cnt;
  int ack_mark;
  int del_cnt;
  int del_mark;
  int first_cyc;
  int last_cyc;
  logic force_ack;
  logic pend;
  logic [5:0] pend_addr;

  ifetch_unit #(.PCW(6), .DW(32)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_out     (ins_out),
    .pc_out      (pc_out),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory: ack on the lat-th cycle of a request
  assign imem_ack = force_ack |
                    (imem_req && (wcnt >= lat - 1));
  assign imem_rdata = TAG | 32'(imem_addr);

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      wcnt <= 0;
    else if (imem_req && !imem_ack)
      wcnt <= wcnt + 1;
    else
      wcnt <= 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_n && imem_req && imem_ack)
      ack_cnt <= ack_cnt + 1;
  end

  // protocol + scoreboard monitor
  always @(negedge clk) begin
    int e;
    if (!clr_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", 32'(imem_addr), 32'(pend_addr));
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
      if (ins_valid && ins_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("extra_pop", 32'(ins_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pc", 32'(pc_out), 32'(e));
          chk("ins", ins_out, TAG | 32'(e));
          if (del_cnt == del_mark)
            first_cyc = cyc;
          last_cyc = cyc;
          del_cnt++;
        end
      end
    end
  end

  task automatic apply_reset(input int l);
    @(posedge clk);
    #1;
    clr_n     = 1'b0;
    ins_ready = 1'b0;
    redirect  = 1'b0;
    force_ack = 1'b0;
    lat       = l;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    ack_mark = ack_cnt;
    del_mark = del_cnt;
    clr_n    = 1'b1;
  endtask

  task automatic push_seq(input int start, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back((start + i) % 64);
  endtask

  task automatic drain(input int budget);
    ins_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    ins_ready = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    cyc         = 0;
    ack_cnt     = 0;
    del_cnt     = 0;
    ack_mark    = 0;
    del_mark    = 0;
    first_cyc   = 0;
    last_cyc    = 0;
    pend        = 1'b0;
    pend_addr   = '0;
    lat         = 1;
    force_ack   = 1'b0;
    clr_n       = 1'b0;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins_out, 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);

    // zero-wait stream with PC wrap
    apply_reset(1);
    push_seq(0, 67);
    drain(300);
    chk("tput1", 32'(last_cyc - first_cyc), 32'd66);

    // back-pressure: only two fetched, no request while full
    apply_reset(1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_acks", 32'(ack_cnt - ack_mark), 32'd2);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(ins_valid), 32'd1);
    chk("bp_pc", 32'(pc_out), 32'd0);
    push_seq(0, 3);
    drain(50);

    // 3-cycle memory, then redirect during fetch of PC 5
    apply_reset(3);
    push_seq(0, 5);
    drain(100);
    chk("tput3", 32'(last_cyc - first_cyc), 32'd12);
    redirect    = 1'b1;
    redirect_pc = 6'h20;
    exp_q.delete();
    push_seq(32, 3);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", 32'(imem_addr), 32'd5);
    drain(100);

    // redirect with stray ack and pop at count 2
    apply_reset(1);
    repeat (5) @(posedge clk);
    #1;
    chk("full_req", 32'(imem_req), 32'd0);
    ins_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 6'h3E;
    force_ack   = 1'b1;
    exp_q.delete();
    push_seq(62, 4);
    @(posedge clk);
    #1;
    redirect  = 1'b0;
    force_ack = 1'b0;
    chk("rd_empty", 32'(ins_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(ins_valid), 32'd1);
    chk("rd_pc", 32'(pc_out), 32'h3E);
    drain(50);

    // async reset mid-fetch with one entry queued
    apply_reset(3);
    repeat (4) @(posedge clk);
    #1;
    chk("ar_pre_valid", 32'(ins_valid), 32'd1);
    chk("ar_pre_req", 32'(imem_req), 32'd1);
    #3;
    clr_n = 1'b0;
    #1;
    chk("ar_valid", 32'(ins_valid), 32'd0);
    chk("ar_req", 32'(imem_req), 32'd0);
    apply_reset(1);
    push_seq(0, 3);
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
